sw6_level_dac: RTL and testbench

//  Encoder counterpart of the 6-position switch decoder. Converts a 3-bit switch

---
 rtl/sw6_level_dac.sv | 130 +++++++++++++
 tb/tb_sw6_level_dac.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sw6_level_dac.sv
// Switch position (0..5) to 8-bit level, emitted as a 256-clock PWM stream.
// Optional level slewing is compiled in with `define SW6_LEVEL_DAC_SLEW_EN.
module sw6_level_dac #(
   parameter int CODE_STEP = 51,
   parameter int SLEW_STEP = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pos_valid,
   output logic       pos_ready,
   input  logic [2:0] pos,
   output logic       pwm_out,
   output logic [7:0] level,
   output logic       busy,
   output logic       err
);

`ifdef SW6_LEVEL_DAC_SLEW_EN
   typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, SLEW = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1} state_t;
`endif

   state_t     state_reg, state_next;
   logic [7:0] cnt_reg;
   logic [7:0] level_reg;
   logic [7:0] target_reg;
   logic       pwm_reg;
   logic       err_reg;
   logic       boundary;
   logic       accept;
   logic       pos_legal;
   logic [7:0] pos_level;

   assign boundary  = (cnt_reg == 8'd255);
   assign accept    = pos_valid && pos_ready;
   assign pos_legal = (pos <= 3'd5);
   assign pos_level = 8'(int'(pos) * CODE_STEP);

`ifdef SW6_LEVEL_DAC_SLEW_EN
   localparam logic [7:0] SLEW_STEP_L = 8'(SLEW_STEP);
   logic [7:0] diff, step_amt, slew_level;
   logic       rising;

   // Step toward the target, clamping the final step so it never overshoots.
   always_comb begin
      rising     = (target_reg >= level_reg);
      diff       = rising ? (target_reg - level_reg) : (level_reg - target_reg);
      step_amt   = (diff < SLEW_STEP_L) ? diff : SLEW_STEP_L;
      slew_level = rising ? (level_reg + step_amt) : (level_reg - step_amt);
   end
`else
   if (SLEW_STEP < 0) begin : g_unused_slew_step
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept && pos_legal) begin
               state_next = PENDING;
            end
         end
         PENDING: begin
            if (boundary) begin
`ifdef SW6_LEVEL_DAC_SLEW_EN
               state_next = (slew_level == target_reg) ? IDLE : SLEW;
`else
               state_next = IDLE;
`endif
            end
         end
`ifdef SW6_LEVEL_DAC_SLEW_EN
         SLEW: begin
            if (boundary && (slew_level == target_reg)) begin
               state_next = IDLE;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      pos_ready = (state_reg == IDLE) && !rst;
      busy      = (state_reg != IDLE);
   end

   // Level only changes on the cnt==255 cycle, so the new value is first
   // compared at cnt==0 and every period is generated with one level.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg    <= 8'd0;
         level_reg  <= 8'd0;
         target_reg <= 8'd0;
         pwm_reg    <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         cnt_reg <= cnt_reg + 8'd1;
         pwm_reg <= (cnt_reg < level_reg) || (level_reg == 8'd255);
         err_reg <= accept && !pos_legal;
         if (accept && pos_legal) begin
            target_reg <= pos_level;
         end
`ifdef SW6_LEVEL_DAC_SLEW_EN
         if (boundary && ((state_reg == PENDING) || (state_reg == SLEW))) begin
            level_reg <= slew_level;
         end
`else
         if (boundary && (state_reg == PENDING)) begin
            level_reg <= target_reg;
         end
`endif
      end
   end

   assign pwm_out = pwm_reg;
   assign level   = level_reg;
   assign err     = err_reg;

endmodule

// File: tb/tb_sw6_level_dac.sv
// Self-checking bench for sw6_level_dac: vector table, corner sequences and
// randomized traffic against a period-level behavioural model.
module tb_sw6_level_dac;

   localparam int SETTLE_LIMIT = 20000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pos_valid = 1'b0;
   logic [2:0] pos = 3'd0;
   logic       pos_ready;
   logic       pwm_out;
   logic [7:0] level;
   logic       busy;
   logic       err;

   int checks = 0;
   int errors = 0;

   // Model: cycle position within the period, current level, target, and
   // whether a change is outstanding.
   int m_cnt = 0;
   int m_level = 0;
   int m_target = 0;
   bit m_busy = 1'b0;
   bit m_err = 1'b0;
   bit m_pwm = 1'b0;

   typedef struct {
      int pos;
      bit exp_err;
      int exp_level;
      int exp_high;
   } vec_t;

   vec_t vecs[8];

   sw6_level_dac dut (
      .clk       (clk),
      .rst       (rst),
      .pos_valid (pos_valid),
      .pos_ready (pos_ready),
      .pos       (pos),
      .pwm_out   (pwm_out),
      .level     (level),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   // Called at a negedge: drive, compare outputs against the model, then
   // advance the model across the next rising edge.
   task automatic step(input bit v, input int p, input bit r);
      bit acc;
      int d;
      pos_valid = v;
      pos       = 3'(p);
      rst       = r;
      #1;
      chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
      chk("level", 32'(level), 32'(m_level));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("err", 32'(err), 32'(m_err));
      chk("pos_ready", 32'(pos_ready), 32'(!r && !m_busy));
      @(posedge clk);
      if (r) begin
         m_cnt = 0; m_level = 0; m_target = 0;
         m_busy = 1'b0; m_err = 1'b0; m_pwm = 1'b0;
      end else begin
         acc   = v && !m_busy;
         m_pwm = (m_cnt < m_level) || (m_level == 255);
         m_err = acc && (p >= 6);
         if (m_busy && m_cnt == 255) begin
`ifdef SW6_LEVEL_DAC_SLEW_EN
            d = m_target - m_level;
            if (d > 4) m_level = m_level + 4;
            else if (d < -4) m_level = m_level - 4;
            else m_level = m_target;
            m_busy = (m_level != m_target);
`else
            d = 0;
            m_level = m_target;
            m_busy  = 1'b0;
`endif
         end
         if (acc && p <= 5) begin
            m_target = p * 51;
            m_busy   = 1'b1;
            $display("accept pos=%0d target=%0d at cnt=%0d", p, m_target, m_cnt);
         end else if (acc) begin
            $display("reject pos=%0d at cnt=%0d", p, m_cnt);
         end
         m_cnt = (m_cnt + 1) % 256;
      end
      @(negedge clk);
   endtask

   task automatic settle(output int n);
      n = 0;
      while (busy === 1'b1 && n < SETTLE_LIMIT) begin
         step(1'b0, 0, 1'b0);
         n++;
      end
      chk("settle_timeout", 32'(n >= SETTLE_LIMIT), 32'd0);
   endtask

   initial begin
      int n;
      int hi;

      vecs[0] = '{3, 1'b0, 153, 153};
      vecs[1] = '{6, 1'b1, 153, 153};
      vecs[2] = '{5, 1'b0, 255, 256};
      vecs[3] = '{0, 1'b0, 0, 0};
      vecs[4] = '{7, 1'b1, 0, 0};
      vecs[5] = '{1, 1'b0, 51, 51};
      vecs[6] = '{4, 1'b0, 204, 204};
      vecs[7] = '{2, 1'b0, 102, 102};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      step(1'b0, 0, 1'b1);
      chk("reset_level", 32'(level), 32'd0);
      chk("reset_pwm", 32'(pwm_out), 32'd0);

      for (int i = 0; i < 8; i++) begin
         step(1'b1, vecs[i].pos, 1'b0);
         chk("vec_err", 32'(err), 32'(vecs[i].exp_err));
         settle(n);
         step(1'b0, 0, 1'b0);
         hi = 0;
         for (int c = 0; c < 256; c++) begin
            hi += int'(pwm_out);
            step(1'b0, 0, 1'b0);
         end
         chk("vec_level", 32'(level), 32'(vecs[i].exp_level));
         chk("vec_duty", 32'(hi), 32'(vecs[i].exp_high));
      end

      // Accept on the boundary cycle waits for the following boundary.
      while (m_cnt != 255) step(1'b0, 0, 1'b0);
      step(1'b1, 1, 1'b0);
      settle(n);
`ifndef SW6_LEVEL_DAC_SLEW_EN
      chk("boundary_accept_latency", 32'(n), 32'd256);
`endif
      chk("boundary_accept_level", 32'(level), 32'd51);

      // Same level re-requested: busy for one boundary, level unchanged.
      step(1'b1, 1, 1'b0);
      chk("same_level_busy", 32'(busy), 32'd1);
      settle(n);
      chk("same_level_level", 32'(level), 32'd51);

      // Requests while busy are dropped without err.
      step(1'b1, 4, 1'b0);
      step(1'b1, 5, 1'b0);
      step(1'b1, 7, 1'b0);
      settle(n);
      chk("ignored_level", 32'(level), 32'd204);

      // Reset mid-transition discards the pending target.
      step(1'b1, 1, 1'b0);
      repeat (10) step(1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b1);
      chk("midreset_level", 32'(level), 32'd0);
      chk("midreset_busy", 32'(busy), 32'd0);
      chk("midreset_pwm", 32'(pwm_out), 32'd0);
      step(1'b0, 0, 1'b0);

      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 4) == 0, int'($urandom_range(0, 7)), ($urandom % 600) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
